// File: rtl/johnson_counter_param_if.sv
// rtl/johnson_counter_param_if.sv - control/status bundle for johnson_counter_param
//
// Purpose: groups the counter's control inputs and decoded outputs.
// Ports (STAGES = ring length N, PW = clog2(2N)):
//   enable      1     advance one phase per clock
//   dir         1     0 = forward, 1 = backward
//   clear       1     synchronous return to phase 0, clears err
//   load        1     synchronous load of load_phase
//   load_phase  PW    phase index to load
//   dout_q      N     raw ring state
//   dout_j      2N    one-hot phase decode (all zero when ring is illegal)
//   phase       PW    binary phase index
//   wrap        1     one-cycle pulse after an enabled wrap-around step
//   err         1     sticky illegal-state / bad-load flag
// modport master: drives controls, observes outputs; modport slave: the counter.

interface johnson_counter_param_if #(
  parameter int STAGES = 4
);
  localparam int PW = $clog2(2 * STAGES);

  logic                  enable;
  logic                  dir;
  logic                  clear;
  logic                  load;
  logic [PW-1:0]         load_phase;
  logic [STAGES-1:0]     dout_q;
  logic [2*STAGES-1:0]   dout_j;
  logic [PW-1:0]         phase;
  logic                  wrap;
  logic                  err;

  modport master (
    output enable, dir, clear, load, load_phase,
    input  dout_q, dout_j, phase, wrap, err
  );

  modport slave (
    input  enable, dir, clear, load, load_phase,
    output dout_q, dout_j, phase, wrap, err
  );
endinterface

// File: rtl/johnson_counter_param.sv
// rtl/johnson_counter_param.sv - parametrised Johnson counter with phase decode
//
// Purpose: STAGES-bit twisted-ring counter producing 2*STAGES phases, with
// enable, direction, clear, phase load, binary phase index, wrap pulse and
// illegal-state detection that forces the ring back to phase 0.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   bus    slave modport of johnson_counter_param_if (controls and outputs)

module johnson_counter_param #(
  parameter int STAGES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  johnson_counter_param_if.slave  bus
);

  localparam int PW  = $clog2(2 * STAGES);
  localparam int NPH = 2 * STAGES;
  localparam logic [PW:0] NPH_W = (PW + 1)'(NPH);

  // Ring pattern of phase k: low k bits set while filling (k <= N),
  // then the set bits drain from the bottom, leaving the top 2N-k set.
  function automatic logic [STAGES-1:0] legal_state(input int k);
    logic [STAGES-1:0] s;
    s = '0;
    for (int i = 0; i < STAGES; i++) begin
      s[i] = (k <= STAGES) ? (i < k) : (i >= k - STAGES);
    end
    return s;
  endfunction

  logic [STAGES-1:0] q_reg;
  logic [STAGES-1:0] q_next;
  logic [STAGES-1:0] q_load;
  logic              err_reg;
  logic              err_next;
  logic              wrap_reg;
  logic              wrap_next;
  logic [NPH-1:0]    match;
  logic              legal;
  logic [PW-1:0]     phase_c;
  logic              load_ok;

  // Exact compare against each legal pattern; an illegal ring matches none,
  // which gives the all-zero one-hot and phase 0 for free.
  generate
    for (genvar k = 0; k < NPH; k++) begin : g_dec
      localparam logic [STAGES-1:0] LEGAL_K = legal_state(k);
      assign match[k] = (q_reg == LEGAL_K);
    end
  endgenerate

  always_comb begin
    legal   = |match;
    phase_c = '0;
    for (int k = 0; k < NPH; k++) begin
      if (match[k]) begin
        phase_c = phase_c | PW'(k);
      end
    end
  end

  always_comb begin
    q_load  = '0;
    load_ok = ({1'b0, bus.load_phase} < NPH_W);
    for (int k = 0; k < NPH; k++) begin
      if (bus.load_phase == PW'(k)) begin
        q_load = legal_state(k);
      end
    end
  end

  // Priority: clear > load > illegal-correct > enable > hold.
  always_comb begin
    q_next    = q_reg;
    err_next  = err_reg;
    wrap_next = 1'b0;
    if (bus.clear) begin
      q_next   = '0;
      err_next = 1'b0;
    end else if (bus.load) begin
      if (load_ok) begin
        q_next = q_load;
      end else begin
        err_next = 1'b1;
      end
    end else if (!legal) begin
      q_next   = '0;
      err_next = 1'b1;
    end else if (bus.enable) begin
      if (!bus.dir) begin
        q_next    = {q_reg[STAGES-2:0], ~q_reg[STAGES-1]};
        wrap_next = match[NPH-1];
      end else begin
        q_next    = {~q_reg[0], q_reg[STAGES-1:1]};
        wrap_next = match[0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_reg    <= '0;
      err_reg  <= 1'b0;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      err_reg  <= err_next;
      wrap_reg <= wrap_next;
    end
  end

  assign bus.dout_q = q_reg;
  assign bus.dout_j = match;
  assign bus.phase  = phase_c;
  assign bus.wrap   = wrap_reg;
  assign bus.err    = err_reg;

endmodule

// File: tb/tb_johnson_counter_param.sv
// tb/tb_johnson_counter_param.sv - directed self-checking bench for johnson_counter_param

module tb_johnson_counter_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, dr, clr, ld, ld3;
  logic [2:0] ld_ph, ldp3;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  johnson_counter_param_if #(.STAGES(2)) b2 ();
  johnson_counter_param_if #(.STAGES(3)) b3 ();
  johnson_counter_param_if #(.STAGES(4)) b4 ();
  johnson_counter_param_if #(.STAGES(8)) b8 ();

  johnson_counter_param #(.STAGES(2)) dut2 (.clock(clk), .reset(rst), .bus(b2));
  johnson_counter_param #(.STAGES(3)) dut3 (.clock(clk), .reset(rst), .bus(b3));
  johnson_counter_param #(.STAGES(4)) dut4 (.clock(clk), .reset(rst), .bus(b4));
  johnson_counter_param #(.STAGES(8)) dut8 (.clock(clk), .reset(rst), .bus(b8));

  assign b2.enable = en;  assign b2.dir = dr;  assign b2.clear = clr;
  assign b3.enable = en;  assign b3.dir = dr;  assign b3.clear = clr;
  assign b4.enable = en;  assign b4.dir = dr;  assign b4.clear = clr;
  assign b8.enable = en;  assign b8.dir = dr;  assign b8.clear = clr;
  assign b2.load = 1'b0;  assign b2.load_phase = '0;
  assign b8.load = 1'b0;  assign b8.load_phase = '0;
  assign b3.load = ld3;   assign b3.load_phase = ldp3;
  assign b4.load = ld;    assign b4.load_phase = ld_ph;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_q(input int k, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (k <= n) r[i] = (i < k);
      else        r[i] = (i >= k - n);
    end
    return r;
  endfunction

  task automatic check_inst(input string tag, input int n, inout int k, input logic d,
                            input logic [31:0] q, input logic [31:0] j,
                            input logic [31:0] ph, input logic [31:0] w);
    logic ew;
    if (!d) begin
      ew = (k == 2 * n - 1);
      k  = (k + 1) % (2 * n);
    end else begin
      ew = (k == 0);
      k  = (k + 2 * n - 1) % (2 * n);
    end
    check({tag, "_q"},    q,  model_q(k, n));
    check({tag, "_j"},    j,  32'(1) << k);
    check({tag, "_ph"},   ph, 32'(k));
    check({tag, "_wrap"}, w,  32'(ew));
  endtask

  logic [3:0] q_fwd [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};
  int         bd_ph [6] = '{7, 6, 5, 6, 7, 0};
  logic       bd_dr [6] = '{1, 1, 1, 0, 0, 0};
  logic       bd_w  [6] = '{1, 0, 0, 0, 0, 1};

  initial begin
    int k2, k3, k4, k8;
    rst = 1'b1; en = 0; dr = 0; clr = 0; ld = 0; ld3 = 0; ld_ph = '0; ldp3 = '0;
    #12;
    check("rst_q",    32'(b4.dout_q), 32'h0);
    check("rst_j",    32'(b4.dout_j), 32'h1);
    check("rst_ph",   32'(b4.phase),  32'h0);
    check("rst_wrap", 32'(b4.wrap),   32'h0);
    check("rst_err",  32'(b4.err),    32'h0);
    rst = 1'b0;

    // Forward full cycle on 4 stages.
    en = 1; dr = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("fwd_q",    32'(b4.dout_q), 32'(q_fwd[i % 8]));
      check("fwd_ph",   32'(b4.phase),  32'(i % 8));
      check("fwd_j",    32'(b4.dout_j), 32'(1) << (i % 8));
      check("fwd_wrap", 32'(b4.wrap),   32'(i == 8));
    end

    // Backward with wrap, then direction change mid-sequence.
    for (int i = 0; i < 6; i++) begin
      dr = bd_dr[i];
      step();
      check("bd_ph",   32'(b4.phase),  32'(bd_ph[i]));
      check("bd_q",    32'(b4.dout_q), 32'(q_fwd[bd_ph[i]]));
      check("bd_wrap", 32'(b4.wrap),   32'(bd_w[i]));
    end
    en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_ph",   32'(b4.phase), 32'h0);
      check("hold_wrap", 32'(b4.wrap),  32'h0);
    end

    // Load and clear on 4 stages.
    ld = 1; ld_ph = 3'd5;
    step();
    check("ld5_q",    32'(b4.dout_q), 32'b1110);
    check("ld5_ph",   32'(b4.phase),  32'd5);
    check("ld5_err",  32'(b4.err),    32'h0);
    check("ld5_wrap", 32'(b4.wrap),   32'h0);
    clr = 1; ld_ph = 3'd3;
    step();
    check("clrld_q",   32'(b4.dout_q), 32'h0);
    check("clrld_err", 32'(b4.err),    32'h0);
    clr = 0; ld = 0;

    // Bad load on 3 stages (phases 6 and 7 are out of range there).
    ld3 = 1; ldp3 = 3'd4;
    step();
    check("ld3_4_q",   32'(b3.dout_q), 32'b110);
    check("ld3_4_ph",  32'(b3.phase),  32'd4);
    ldp3 = 3'd7;
    step();
    check("ld3_bad_q",   32'(b3.dout_q), 32'b110);
    check("ld3_bad_err", 32'(b3.err),    32'h1);
    ldp3 = 3'd3;
    step();
    check("ld3_3_q",   32'(b3.dout_q), 32'b111);
    check("ld3_3_err", 32'(b3.err),    32'h1);
    clr = 1; ldp3 = 3'd6;
    step();
    check("clr3_q",   32'(b3.dout_q), 32'h0);
    check("clr3_err", 32'(b3.err),    32'h0);
    clr = 0; ld3 = 0;

    // Illegal ring state on 4 stages.
    @(negedge clk);
    force dut4.q_reg = 4'b0101;
    #1;
    check("ill_j",   32'(b4.dout_j), 32'h0);
    check("ill_ph",  32'(b4.phase),  32'h0);
    check("ill_err", 32'(b4.err),    32'h0);
    @(posedge clk);
    #1;
    release dut4.q_reg;
    check("cor_err",  32'(b4.err),  32'h1);
    check("cor_wrap", 32'(b4.wrap), 32'h0);
    step();
    check("cor_q",    32'(b4.dout_q), 32'h0);
    check("cor_err2", 32'(b4.err),    32'h1);
    step();
    check("cor_err3", 32'(b4.err),    32'h1);
    clr = 1;
    step();
    check("cor_clr_err", 32'(b4.err), 32'h0);
    clr = 0;

    // Asynchronous reset between edges.
    ld = 1; ld_ph = 3'd6;
    step();
    check("pre_ar_ph", 32'(b4.phase), 32'd6);
    ld = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_q",  32'(b4.dout_q), 32'h0);
    check("ar_j",  32'(b4.dout_j), 32'h1);
    check("ar_ph", 32'(b4.phase),  32'h0);
    #1 rst = 1'b0;
    en = 1; dr = 0;
    step();
    check("ar_ph1", 32'(b4.phase),  32'd1);
    check("ar_q1",  32'(b4.dout_q), 32'b0001);
    en = 0;

    // Parameter sweep: forward then backward across all instances.
    clr = 1;
    step();
    clr = 0;
    k2 = 0; k3 = 0; k4 = 0; k8 = 0;
    en = 1;
    for (int pass = 0; pass < 2; pass++) begin
      dr = (pass == 1);
      for (int i = 0; i < 32; i++) begin
        step();
        check_inst("s2", 2, k2, dr, 32'(b2.dout_q), 32'(b2.dout_j), 32'(b2.phase), 32'(b2.wrap));
        check_inst("s3", 3, k3, dr, 32'(b3.dout_q), 32'(b3.dout_j), 32'(b3.phase), 32'(b3.wrap));
        check_inst("s4", 4, k4, dr, 32'(b4.dout_q), 32'(b4.dout_j), 32'(b4.phase), 32'(b4.wrap));
        check_inst("s8", 8, k8, dr, 32'(b8.dout_q), 32'(b8.dout_j), 32'(b8.phase), 32'(b8.wrap));
      end
    end
    en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
